// File: rtl/ebr_fifo_pkg.sv
// Shared constants and grant encoding for the EBR FIFO controller.
// Grant codes double as one-hot {B, A} vectors.
package ebr_fifo_pkg;

  localparam int unsigned EBR_ADDR_W     = 4;
  localparam int unsigned EBR_DATA_W     = 4;
  localparam int unsigned EBR_DEPTH      = 2 ** EBR_ADDR_W;
  localparam int unsigned EBR_AFULL_LVL  = 12;
  localparam int unsigned EBR_AEMPTY_LVL = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } gnt_e;

endpackage

// File: rtl/ebr_fifo_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; the last winner is remembered
// so that simultaneous requests alternate.
module rr_arb2
  import ebr_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  gnt_e last_q;
  gnt_e gnt_sel;

  always_comb begin
    gnt_sel = GNT_NONE;
    if (enable) begin
      unique case (req)
        2'b01:   gnt_sel = GNT_A;
        2'b10:   gnt_sel = GNT_B;
        2'b11:   gnt_sel = (last_q == GNT_A) ? GNT_B : GNT_A;
        default: gnt_sel = GNT_NONE;
      endcase
    end
  end

  assign gnt = gnt_sel;

  // Reset to B so that A wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_B;
    end else if (gnt_sel != GNT_NONE) begin
      last_q <= gnt_sel;
    end
  end

endmodule

// File: rtl/ebr_fifo_ctrl.sv
// Single-clock FIFO sequencer for a 16x4 dual-port EBR: two arbitrated writers, one reader,
// occupancy flags and sticky read-error status.
module ebr_fifo_ctrl
  import ebr_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W     = EBR_ADDR_W,
  parameter int unsigned DATA_W     = EBR_DATA_W,
  parameter int unsigned AFULL_LVL  = EBR_AFULL_LVL,
  parameter int unsigned AEMPTY_LVL = EBR_AEMPTY_LVL
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              WrReqA,
  input  logic              WrReqB,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  output logic              WrGntA,
  output logic              WrGntB,
  input  logic              RdReq,
  output logic              RdValid,
  output logic [DATA_W-1:0] RdData,
  output logic              Empty,
  output logic              Full,
  output logic              AlmostEmpty,
  output logic              AlmostFull,
  output logic [ADDR_W:0]   Count,
  output logic              RdErr,
  output logic [DATA_W-1:0] MemData,
  output logic [ADDR_W-1:0] MemWrAddress,
  output logic [ADDR_W-1:0] MemRdAddress,
  output logic              MemWrEn,
  output logic              MemRdEn,
  input  logic [DATA_W-1:0] MemQ
);

  localparam logic [ADDR_W:0] DepthCnt  = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AfullCnt  = (ADDR_W + 1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AemptyCnt = (ADDR_W + 1)'(AEMPTY_LVL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q;
  logic              rd_err_q, rd_err_d;

  logic       wr_ok;
  logic       wr_acc;
  logic       rd_ok;
  logic [1:0] gnt;

  assign Empty       = (count_q == '0);
  assign Full        = (count_q == DepthCnt);
  assign AlmostFull  = (count_q >= AfullCnt);
  assign AlmostEmpty = (count_q <= AemptyCnt);
  assign Count       = count_q;

  // Reset_n gates the grants so nothing is enabled while reset is held.
  assign wr_ok = ~Full & Reset_n;

  rr_arb2 u_arb (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .req    ({WrReqB, WrReqA}),
    .enable (wr_ok),
    .gnt    (gnt)
  );

  assign WrGntA = gnt[0];
  assign WrGntB = gnt[1];
  assign wr_acc = gnt[0] | gnt[1];
  assign rd_ok  = RdReq & ~Empty;

  assign MemWrEn      = wr_acc;
  assign MemRdEn      = rd_ok;
  assign MemData      = gnt[1] ? DataB : DataA;
  assign MemWrAddress = wr_ptr_q;
  assign MemRdAddress = rd_ptr_q;
  assign RdValid      = rd_valid_q;
  assign RdData       = MemQ;
  assign RdErr        = rd_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_err_d = rd_err_q | (RdReq & Empty);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_acc, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
      rd_err_q   <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// Randomised scoreboard bench for ebr_fifo_ctrl with a behavioural EBR beside it.
module tb_ebr_fifo_ctrl;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       WrReqA, WrReqB, RdReq;
  logic [3:0] DataA, DataB;
  logic       WrGntA, WrGntB, RdValid;
  logic [3:0] RdData;
  logic       Empty, Full, AlmostEmpty, AlmostFull;
  logic [4:0] Count;
  logic       RdErr;
  logic [3:0] MemData, MemWrAddress, MemRdAddress, MemQ;
  logic       MemWrEn, MemRdEn;

  ebr_fifo_ctrl dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .WrReqA       (WrReqA),
    .WrReqB       (WrReqB),
    .DataA        (DataA),
    .DataB        (DataB),
    .WrGntA       (WrGntA),
    .WrGntB       (WrGntB),
    .RdReq        (RdReq),
    .RdValid      (RdValid),
    .RdData       (RdData),
    .Empty        (Empty),
    .Full         (Full),
    .AlmostEmpty  (AlmostEmpty),
    .AlmostFull   (AlmostFull),
    .Count        (Count),
    .RdErr        (RdErr),
    .MemData      (MemData),
    .MemWrAddress (MemWrAddress),
    .MemRdAddress (MemRdAddress),
    .MemWrEn      (MemWrEn),
    .MemRdEn      (MemRdEn),
    .MemQ         (MemQ)
  );

  always #5 Clock = ~Clock;

  // Behavioural dual-port EBR with registered read.
  logic [3:0] ebr [16];
  always @(posedge Clock) begin
    if (MemWrEn) ebr[MemWrAddress] <= MemData;
    if (MemRdEn) MemQ <= ebr[MemRdAddress];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, pointers as running totals.
  logic [3:0] mq[$];
  logic [3:0] sb[$];
  int         wr_tot, rd_tot;
  bit         last_b, rd_err_m;
  bit         pa, pb;
  logic [3:0] da, db;

  task automatic model_reset();
    mq.delete();
    sb.delete();
    wr_tot = 0;
    rd_tot = 0;
    last_b = 1'b1;
    rd_err_m = 1'b0;
    pa = 1'b0;
    pb = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_empty", Empty, 1);
    chk("rst_aempty", AlmostEmpty, 1);
    chk("rst_full", Full, 0);
    chk("rst_afull", AlmostFull, 0);
    chk("rst_count", Count, 0);
    chk("rst_rdvalid", RdValid, 0);
    chk("rst_rderr", RdErr, 0);
    chk("rst_memwren", MemWrEn, 0);
    chk("rst_memrden", MemRdEn, 0);
    chk("rst_gnt", {WrGntB, WrGntA}, 0);
  endtask

  // Monitor: every accepted read must produce RdValid with the queued word one edge later.
  always begin
    @(posedge Clock);
    #1;
    if (RdValid) begin
      if (sb.size() == 0) chk("rdvalid_spurious", RdValid, 0);
      else chk("rd_data", RdData, sb.pop_front());
    end else if (sb.size() != 0) begin
      chk("rdvalid_latency", RdValid, 1);
      sb.delete();
    end
  end

  initial begin
    int  cnt, pw, pr, phase;
    bit  ga, gb, rd_ok;

    Reset_n = 1'b0;
    WrReqA = 0; WrReqB = 0; RdReq = 0; DataA = 0; DataB = 0;
    model_reset();
    repeat (2) @(negedge Clock);
    #1;
    check_reset_state();
    Reset_n = 1'b1;

    for (int it = 0; it < 1200; it++) begin
      @(negedge Clock);
      phase = (it / 100) % 4;
      case (phase)
        0:       begin pw = 90; pr = 10; end
        1:       begin pw = 15; pr = 90; end
        default: begin pw = 50; pr = 50; end
      endcase
      if (!pa) begin pa = ($urandom_range(99) < pw) || (phase == 3); da = 4'($urandom); end
      if (!pb) begin pb = ($urandom_range(99) < pw) || (phase == 3); db = 4'($urandom); end
      WrReqA = pa; DataA = da;
      WrReqB = pb; DataB = db;
      RdReq  = ($urandom_range(99) < pr);

      if (it == 650) begin
        // Asynchronous reset in the middle of traffic.
        Reset_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        continue;
      end
      Reset_n = 1'b1;
      #1;

      cnt = mq.size();
      ga = 0; gb = 0;
      if (cnt < 16) begin
        if (pa && pb) begin ga = last_b; gb = !last_b; end
        else begin ga = pa; gb = pb; end
      end
      rd_ok = RdReq && (cnt != 0);

      chk("count", Count, cnt);
      chk("empty", Empty, cnt == 0);
      chk("full", Full, cnt == 16);
      chk("afull", AlmostFull, cnt >= 12);
      chk("aempty", AlmostEmpty, cnt <= 4);
      chk("rderr", RdErr, rd_err_m);
      chk("gnt_a", WrGntA, ga);
      chk("gnt_b", WrGntB, gb);
      chk("memwren", MemWrEn, ga | gb);
      chk("memrden", MemRdEn, rd_ok);
      chk("wr_addr", MemWrAddress, wr_tot % 16);
      chk("rd_addr", MemRdAddress, rd_tot % 16);
      if (ga) chk("memdata_a", MemData, da);
      if (gb) chk("memdata_b", MemData, db);

      if (rd_ok) begin
        sb.push_back(mq.pop_front());
        rd_tot++;
      end
      if (RdReq && cnt == 0) rd_err_m = 1'b1;
      if (ga) begin mq.push_back(da); wr_tot++; last_b = 1'b0; pa = 1'b0; end
      if (gb) begin mq.push_back(db); wr_tot++; last_b = 1'b1; pb = 1'b0; end
    end

    @(negedge Clock);
    WrReqA = 0; WrReqB = 0; RdReq = 0;
    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
